uart_rx_mc: RTL

UART_RX_MC -- requirements
Module: uart_rx_mc

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 73 +++++++
 rtl/uart_rx_mc.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and receiver state encoding for uart_rx_mc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous FIFO with occupancy count and show-ahead head.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == (c_aw+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = i_wr_en && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_rx_mc.sv
// ============================================================================
// Module      : uart_rx_mc
// Description : Oversampling UART receiver with parity/framing checks and FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_mc
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk_rx,
    input  logic                          rst,
    input  logic                          datain_rx,
    input  logic                          sample_tick,
    input  logic                          rx_enable,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    output logic                          rx_busy,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                    c_tick_w   = $clog2(OVERSAMPLE);
    localparam logic [c_tick_w-1:0]   c_tick_mid = c_tick_w'(OVERSAMPLE/2 - 1);
    localparam logic [c_tick_w-1:0]   c_tick_end = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [3:0]            c_bit_last = 4'(DATA_BITS - 1);
    localparam logic                  c_stop_end = 1'(STOP_BITS - 1);
    localparam logic                  c_par_odd  = (PARITY_MODE == PARITY_ODD);
    localparam logic                  c_has_par  = (PARITY_MODE != PARITY_NONE);
    localparam int                    c_entry_w  = DATA_BITS + 2;

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_line;
    rx_state_e              r_state;
    logic [c_tick_w-1:0]    r_tick;
    logic [3:0]             r_bit_cnt;
    logic                   r_stop_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_overrun;
    logic                   w_bit_end;
    logic                   w_ferr_now;
    logic                   w_wr_en;
    logic [c_entry_w-1:0]   w_wr_data;
    logic [c_entry_w-1:0]   w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_overflow;

    // Idle-high reset value keeps a reset from looking like a start bit.
    always_ff @(posedge clk_rx) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= datain_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line     = r_sync2;
    assign w_bit_end  = sample_tick && (r_tick == c_tick_end);
    assign w_ferr_now = r_ferr | ~w_line;
    assign w_wr_en    = (r_state == ST_STOP) && w_bit_end && (r_stop_cnt == c_stop_end);
    assign w_wr_data  = {w_ferr_now, r_perr, r_shift};

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tick     <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_line && rx_enable) begin
                        r_state <= ST_START;
                        r_tick  <= '0;
                    end
                end
                ST_START: begin
                    if (sample_tick) begin
                        if (r_tick == c_tick_mid) begin
                            r_tick <= '0;
                            if (!w_line) begin
                                r_state   <= ST_DATA;
                                r_bit_cnt <= '0;
                                r_perr    <= 1'b0;
                                r_ferr    <= 1'b0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_bit_last) begin
                            r_stop_cnt <= 1'b0;
                            r_state    <= c_has_par ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (sample_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_perr  <= w_line ^ (^r_shift) ^ c_par_odd;
                        r_state <= ST_STOP;
                    end else if (sample_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_tick <= '0;
                        r_ferr <= w_ferr_now;
                        if (r_stop_cnt == c_stop_end) begin
                            r_state <= w_ferr_now ? ST_WAIT_HIGH : ST_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end else if (sample_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_line) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A full FIFO is always non-empty, so rd_en alone means a pop makes room.
    assign w_overflow = w_wr_en && w_fifo_full && !rd_en;

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_overflow) begin
            r_overrun <= 1'b1;
        end else if (err_clr) begin
            r_overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_rx),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (rd_en),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (fifo_count)
    );

    assign {rx_ferr, rx_perr, rx_data} = w_head;
    assign rx_valid = !w_fifo_empty;
    assign rx_busy  = (r_state != ST_IDLE);
    assign overrun  = r_overrun;

endmodule

`default_nettype wire
